hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset: clk is the only clock and rst is the reset, both as named below.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 id_valid  input  1  ID stage holds a real instruction.
REQ-005 id_rs, id_rt  input  5 each  ID source register numbers.
REQ-006 id_uses_rs, id_uses_rt  input  1 each  the ID instruction reads that source.
REQ-007 id_is_branch  input  1  the ID instruction compares operands in ID.
REQ-008 id_reg_write, id_mem_read  input  1 each  the ID instruction writes a register / is a load.
REQ-009 id_rd  input  5  ID destination register number.
REQ-010 flush  input  1  kill the ID instruction (taken branch or jump).
REQ-011 stall  output  1  a hazard is holding ID.
REQ-012 pc_write, if_id_write  output  1 each  PC and IF/ID register update enables.
REQ-013 id_ex_bubble  output  1  inject a NOP into ID/EX.
REQ-014 ex_rd, mem_rd, wb_rd  output  5 each  destination register of the in-flight instruction per stage.
REQ-015 ex_reg_write, mem_reg_write, wb_reg_write  output  1 each  the stage entry is valid and writes a register.
REQ-016 stall_cycles, load_use_events  output  16 each  performance counters.

Function
REQ-017 The scoreboard SHALL hold three entries (EX, MEM, WB); each entry holds {valid, rd, reg_write, mem_read}.
REQ-018 An entry SHALL match a source when the entry is valid, reg_write=1, rd!=0, rd equals the source, and the matching use flag is 1.
REQ-019 For a non-branch instruction, the hazard SHALL be: an EX entry with mem_read=1 that matches rs or rt (load-use).
REQ-020 For a branch instruction (id_is_branch=1), the hazard SHALL be: an EX entry with mem_read=1 that matches, or a MEM entry with mem_read=1 that matches; an EX ALU result is forwarded and does not stall.
REQ-021 Outputs are combinational: stall = hazard & id_valid & !flush.
REQ-022 Outputs are combinational: pc_write = if_id_write = !stall.
REQ-023 Output is combinational: id_ex_bubble = stall | flush.
REQ-024 On every clock edge, MEM SHALL be loaded from EX and WB SHALL be loaded from MEM.
REQ-025 On the same clock edge, EX SHALL be loaded with the ID fields when id_valid & !stall & !flush; otherwise EX SHALL be loaded with valid=0.
REQ-026 A branch behind a load in EX SHALL stall exactly 2 cycles; a non-branch behind a load in EX SHALL stall exactly 1 cycle.
REQ-027 flush SHALL take priority over stall in the same cycle.
REQ-028 The stage outputs ex_rd/mem_rd/wb_rd and *_reg_write SHALL be driven directly from the entries, with reg_write gated by valid.
REQ-029 When the same register matches in several stages, the hazard decision SHALL use all matching entries; the youngest producer does not mask an older load.
REQ-030 id_rs/id_rt = 0 SHALL never cause a stall.

Reset
REQ-031 While rst=1 at a clock edge, all entries SHALL become valid=0 and rd=0, and both counters SHALL become 0.
REQ-032 Asserting rst mid-stall SHALL drop the pending hazard: stall=0 in the cycle after reset when id_valid=0.
REQ-033 rst SHALL take priority over flush and stall.

Configuration
REQ-034 When HAZARD_PERF_COUNT_EN is defined, stall_cycles SHALL increment on each clock edge where stall=1, saturating at 16'hFFFF.
REQ-035 When HAZARD_PERF_COUNT_EN is defined, load_use_events SHALL increment on each edge where stall=1 and the previous cycle's stall was 0, saturating at 16'hFFFF.
REQ-036 When HAZARD_PERF_COUNT_EN is undefined, both counters SHALL be constant 0 and no counter flops SHALL exist.

Verification
REQ-037 Load-use test: issue lw rd=5, then add with rs=5 -> stall=1 for one cycle, id_ex_bubble=1, pc_write=0, then ex_rd=5 valid on the add.
REQ-038 Branch after load: issue lw rd=8, then beq with rt=8 -> stall=1 for two consecutive cycles, then released; with HAZARD_PERF_COUNT_EN defined, stall_cycles=2 and load_use_events=1.
REQ-039 Branch after ALU: issue add rd=3, then beq with rs=3 -> stall=0 and ex_reg_write=1 with ex_rd=3.
REQ-040 Register zero: issue lw rd=0, then add with rs=0 -> stall=0.
REQ-041 Flush during a hazard: lw rd=4, then an add using rs=4 with flush=1 -> stall=0, id_ex_bubble=1, and the EX entry is invalid the next cycle.
REQ-042 Reset mid-stall: assert rst during a branch stall -> all *_reg_write=0 next cycle, counters=0, and stall=0 with id_valid=0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
// Purpose : bundles the ID-stage request signals and the hazard / pipeline
//           status returned by hazard_scoreboard.
// Signals :
//   id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch,
//   id_reg_write, id_mem_read, id_rd, flush      -> driven by the ID stage
//   stall, pc_write, if_id_write, id_ex_bubble,
//   ex_rd, mem_rd, wb_rd, ex/mem/wb_reg_write,
//   stall_cycles, load_use_events                -> driven by the scoreboard
// Modports: master = ID stage / pipeline control, slave = scoreboard.
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if;
   logic        id_valid;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rs;
   logic        id_uses_rt;
   logic        id_is_branch;
   logic        id_reg_write;
   logic        id_mem_read;
   logic [4:0]  id_rd;
   logic        flush;

   logic        stall;
   logic        pc_write;
   logic        if_id_write;
   logic        id_ex_bubble;
   logic [4:0]  ex_rd;
   logic [4:0]  mem_rd;
   logic [4:0]  wb_rd;
   logic        ex_reg_write;
   logic        mem_reg_write;
   logic        wb_reg_write;
   logic [15:0] stall_cycles;
   logic [15:0] load_use_events;

   modport master (
      output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch,
             id_reg_write, id_mem_read, id_rd, flush,
      input  stall, pc_write, if_id_write, id_ex_bubble,
             ex_rd, mem_rd, wb_rd, ex_reg_write, mem_reg_write, wb_reg_write,
             stall_cycles, load_use_events
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch,
             id_reg_write, id_mem_read, id_rd, flush,
      output stall, pc_write, if_id_write, id_ex_bubble,
             ex_rd, mem_rd, wb_rd, ex_reg_write, mem_reg_write, wb_reg_write,
             stall_cycles, load_use_events
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Purpose : tracks the destination registers of the instructions in EX, MEM
//           and WB and holds the ID stage while a source operand depends on a
//           load whose data is not yet available.
//             - ALU consumers read operands in EX: only a load in EX blocks.
//             - Branches compare in ID: a load in EX or in MEM blocks, an ALU
//               result in EX is forwarded.
//           flush kills the ID instruction and overrides the stall.
// Ports   :
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset (clears entries and counters)
//   bus  - hazard_scoreboard_if.slave (ID request in, hazard/stage status out)
// Config  : define HAZARD_PERF_COUNT_EN to build the saturating stall_cycles
//           and load_use_events counters; otherwise both read as 0 and no
//           counter flops exist.
// -----------------------------------------------------------------------------
module hazard_scoreboard (
   input  logic               clk,
   input  logic               rst,
   hazard_scoreboard_if.slave bus
);

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       reg_write;
      logic       mem_read;
   } entry_t;

   localparam entry_t EMPTY_ENTRY = '{valid: 1'b0, rd: 5'd0, reg_write: 1'b0, mem_read: 1'b0};

   entry_t ex_q;
   entry_t ex_d;
   entry_t mem_q;
   entry_t mem_d;
   entry_t wb_q;
   entry_t wb_d;

   logic load_in_ex_hit_s;
   logic load_in_mem_hit_s;
   logic hazard_s;
   logic stall_s;

   // An entry produces a source operand the ID instruction actually reads.
   // Register 0 is hard-wired, so it never creates a dependency.
   function automatic logic entry_hits(input entry_t e, input logic [4:0] src,
                                       input logic src_used);
      entry_hits = e.valid & e.reg_write & (e.rd != 5'd0) & (e.rd == src) & src_used;
   endfunction

   // Hazard detection. Each stage is checked independently so that a younger
   // ALU producer of the same register cannot hide an older load behind it.
   always_comb begin
      load_in_ex_hit_s  = ex_q.mem_read &
                          (entry_hits(ex_q, bus.id_rs, bus.id_uses_rs) |
                           entry_hits(ex_q, bus.id_rt, bus.id_uses_rt));
      load_in_mem_hit_s = mem_q.mem_read &
                          (entry_hits(mem_q, bus.id_rs, bus.id_uses_rs) |
                           entry_hits(mem_q, bus.id_rt, bus.id_uses_rt));
      if (bus.id_is_branch) begin
         hazard_s = load_in_ex_hit_s | load_in_mem_hit_s;
      end else begin
         hazard_s = load_in_ex_hit_s;
      end
      // A flushed instruction is discarded anyway, so it never waits.
      stall_s = hazard_s & bus.id_valid & ~bus.flush;
   end

   assign bus.stall         = stall_s;
   assign bus.pc_write      = ~stall_s;
   assign bus.if_id_write   = ~stall_s;
   assign bus.id_ex_bubble  = stall_s | bus.flush;

   assign bus.ex_rd         = ex_q.rd;
   assign bus.mem_rd        = mem_q.rd;
   assign bus.wb_rd         = wb_q.rd;
   assign bus.ex_reg_write  = ex_q.valid & ex_q.reg_write;
   assign bus.mem_reg_write = mem_q.valid & mem_q.reg_write;
   assign bus.wb_reg_write  = wb_q.valid & wb_q.reg_write;

   // Pipeline advance: older stages always shift, EX takes the ID instruction
   // only when it is really issued, otherwise a bubble.
   always_comb begin
      mem_d = ex_q;
      wb_d  = mem_q;
      ex_d  = EMPTY_ENTRY;
      if (bus.id_valid & ~stall_s & ~bus.flush) begin
         ex_d.valid     = 1'b1;
         ex_d.rd        = bus.id_rd;
         ex_d.reg_write = bus.id_reg_write;
         ex_d.mem_read  = bus.id_mem_read;
      end else begin
         ex_d = EMPTY_ENTRY;
      end
   end

   // Stage entry registers; reset wins over any flush or stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= EMPTY_ENTRY;
         mem_q <= EMPTY_ENTRY;
         wb_q  <= EMPTY_ENTRY;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

`ifdef HAZARD_PERF_COUNT_EN
   logic [15:0] stall_cycles_q;
   logic [15:0] stall_cycles_d;
   logic [15:0] load_use_events_q;
   logic [15:0] load_use_events_d;
   logic        stall_prev_q;
   logic        stall_prev_d;

   // Saturating counters; a new event is the first cycle of a stall run.
   always_comb begin
      stall_prev_d = stall_s;
      if (stall_s && (stall_cycles_q != 16'hFFFF)) begin
         stall_cycles_d = stall_cycles_q + 16'd1;
      end else begin
         stall_cycles_d = stall_cycles_q;
      end
      if (stall_s && !stall_prev_q && (load_use_events_q != 16'hFFFF)) begin
         load_use_events_d = load_use_events_q + 16'd1;
      end else begin
         load_use_events_d = load_use_events_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q    <= 16'd0;
         load_use_events_q <= 16'd0;
         stall_prev_q      <= 1'b0;
      end else begin
         stall_cycles_q    <= stall_cycles_d;
         load_use_events_q <= load_use_events_d;
         stall_prev_q      <= stall_prev_d;
      end
   end

   assign bus.stall_cycles    = stall_cycles_q;
   assign bus.load_use_events = load_use_events_q;
`else
   assign bus.stall_cycles    = 16'd0;
   assign bus.load_use_events = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed scenarios (load-use, branch after load/ALU, r0, flush, reset
// mid-stall) followed by randomized traffic. A reference model reasons about
// "what was issued N cycles ago" and when a load's data becomes usable; the
// expected outputs per cycle are queued and a negedge monitor compares them.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hazard_scoreboard_if bus ();

   hazard_scoreboard dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit       v;
      bit [4:0] rs;
      bit       urs;
      bit [4:0] rt;
      bit       urt;
      bit       br;
      bit       rw;
      bit       ld;
      bit [4:0] rd;
      bit       fl;
   } instr_t;

   // An instruction that actually entered EX at some past edge.
   typedef struct {
      bit       v;
      bit [4:0] rd;
      bit       rw;
      bit       ld;
   } issued_t;

   typedef struct {
      bit [3:0]  ctl;
      bit [17:0] stg;
      bit [31:0] perf;
      int        cyc;
   } exp_t;

   issued_t ago[3];   // ago[k] = what entered EX k+1 edges ago
   exp_t    expq[$];
   int      n_cmp = 0;
   int      n_bad = 0;
   int      cyc   = 0;
   int      exp_sc = 0;
   int      exp_lu = 0;
   bit      prev_stall = 1'b0;

   function automatic instr_t mk(bit v, bit [4:0] rs, bit urs, bit [4:0] rt, bit urt,
                                 bit br, bit rw, bit ld, bit [4:0] rd, bit fl);
      instr_t i;
      i.v = v; i.rs = rs; i.urs = urs; i.rt = rt; i.urt = urt;
      i.br = br; i.rw = rw; i.ld = ld; i.rd = rd; i.fl = fl;
      return i;
   endfunction

   function automatic bit produces(issued_t p, bit [4:0] src, bit used);
      return p.v && p.rw && (p.rd != 5'd0) && (p.rd == src) && used;
   endfunction

   // A load's data is usable by an EX-stage consumer once the load has left
   // EX (1 cycle), and by an ID-stage branch compare once it has left MEM
   // (2 cycles). Any still-unready load producing a source forces a wait.
   function automatic bit model_stall(instr_t i);
      int need = i.br ? 2 : 1;
      bit wait_s = 1'b0;
      for (int age = 0; age < need; age++) begin
         if (ago[age].ld && (produces(ago[age], i.rs, i.urs) || produces(ago[age], i.rt, i.urt)))
            wait_s = 1'b1;
      end
      return wait_s && i.v && !i.fl;
   endfunction

   task automatic step(input instr_t i, input bit r, output bit stalled);
      exp_t e;
      bit   s;
      rst              = r;
      bus.id_valid     = i.v;
      bus.id_rs        = i.rs;
      bus.id_uses_rs   = i.urs;
      bus.id_rt        = i.rt;
      bus.id_uses_rt   = i.urt;
      bus.id_is_branch = i.br;
      bus.id_reg_write = i.rw;
      bus.id_mem_read  = i.ld;
      bus.id_rd        = i.rd;
      bus.flush        = i.fl;
      s = model_stall(i);
      e.ctl = {s, !s, !s, s || i.fl};
      e.stg = {ago[0].rd, ago[0].v && ago[0].rw,
               ago[1].rd, ago[1].v && ago[1].rw,
               ago[2].rd, ago[2].v && ago[2].rw};
`ifdef HAZARD_PERF_COUNT_EN
      e.perf = {exp_sc[15:0], exp_lu[15:0]};
`else
      e.perf = 32'd0;
`endif
      e.cyc = cyc;
      expq.push_back(e);
      @(posedge clk);
      if (r) begin
         for (int k = 0; k < 3; k++) ago[k] = '{1'b0, 5'd0, 1'b0, 1'b0};
         exp_sc = 0;
         exp_lu = 0;
         prev_stall = 1'b0;
      end else begin
         if (s && exp_sc < 65535) exp_sc++;
         if (s && !prev_stall && exp_lu < 65535) exp_lu++;
         prev_stall = s;
         ago[2] = ago[1];
         ago[1] = ago[0];
         if (i.v && !s && !i.fl) ago[0] = '{1'b1, i.rd, i.rw, i.ld};
         else                    ago[0] = '{1'b0, 5'd0, 1'b0, 1'b0};
      end
      cyc++;
      #1;
      stalled = s;
   endtask

   // Present an instruction and hold it in ID until it is issued (bounded).
   task automatic issue(input instr_t i);
      bit st;
      int n = 0;
      do begin
         step(i, 1'b0, st);
         n++;
      end while (st && n < 10);
      n_cmp++;
      if (st) begin
         n_bad++;
         $display("FAIL issue_bound cyc=%0d still stalled after %0d cycles (limit 10)", cyc, n);
      end
   endtask

   task automatic idle(input int n, input bit r);
      bit st;
      for (int k = 0; k < n; k++) step(mk(0,0,0,0,0,0,0,0,0,0), r, st);
   endtask

   // Monitor: the DUT presents its status every cycle; compare mid-cycle.
   always @(negedge clk) begin
      exp_t        e;
      logic [3:0]  a_ctl;
      logic [17:0] a_stg;
      logic [31:0] a_perf;
      if (expq.size() > 0) begin
         e      = expq.pop_front();
         a_ctl  = {bus.stall, bus.pc_write, bus.if_id_write, bus.id_ex_bubble};
         a_stg  = {bus.ex_rd, bus.ex_reg_write, bus.mem_rd, bus.mem_reg_write,
                   bus.wb_rd, bus.wb_reg_write};
         a_perf = {bus.stall_cycles, bus.load_use_events};
         n_cmp++;
         if (a_ctl !== e.ctl) begin
            n_bad++;
            $display("FAIL ctl cyc=%0d {stall,pc_wr,ifid_wr,bubble} got=%b exp=%b", e.cyc, a_ctl, e.ctl);
         end
         n_cmp++;
         if (a_stg !== e.stg) begin
            n_bad++;
            $display("FAIL stage cyc=%0d {ex,mem,wb rd/rw} got=%h exp=%h", e.cyc, a_stg, e.stg);
         end
         n_cmp++;
         if (a_perf !== e.perf) begin
            n_bad++;
            $display("FAIL perf cyc=%0d {stall_cycles,load_use_events} got=%h exp=%h", e.cyc, a_perf, e.perf);
         end
      end
   end

   function automatic instr_t rand_instr();
      instr_t i;
      i.v   = ($urandom_range(0, 7) != 0);
      i.rs  = 5'($urandom_range(0, 7));
      i.rt  = 5'($urandom_range(0, 7));
      i.urs = ($urandom_range(0, 3) != 0);
      i.urt = ($urandom_range(0, 1) != 0);
      i.br  = ($urandom_range(0, 3) == 0);
      i.ld  = ($urandom_range(0, 2) == 0);
      i.rw  = i.ld || ($urandom_range(0, 3) != 0);
      i.rd  = 5'($urandom_range(0, 7));
      i.fl  = ($urandom_range(0, 9) == 0);
      return i;
   endfunction

   initial begin
      bit     st;
      instr_t cur;
      // First edge only establishes a known state; nothing to check yet.
      rst = 1'b1;
      bus.id_valid = 1'b0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
      bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0; bus.id_is_branch = 1'b0;
      bus.id_reg_write = 1'b0; bus.id_mem_read = 1'b0; bus.id_rd = 5'd0; bus.flush = 1'b0;
      @(posedge clk);
      #1;
      idle(2, 1'b1);
      idle(1, 1'b0);

      // Load-use: lw r5; add r?,r5 -> one stall cycle.
      issue(mk(1, 0,0, 0,0, 0, 1,1, 5, 0));
      issue(mk(1, 5,1, 2,1, 0, 1,0, 9, 0));
      idle(3, 1'b0);

      // Branch after load from a fresh counter state: two stall cycles.
      idle(1, 1'b1);
      issue(mk(1, 0,0, 0,0, 0, 1,1, 8, 0));
      issue(mk(1, 1,1, 8,1, 1, 0,0, 0, 0));
      idle(3, 1'b0);

      // Branch after ALU: forwarded, no stall.
      issue(mk(1, 0,0, 0,0, 0, 1,0, 3, 0));
      issue(mk(1, 3,1, 4,1, 1, 0,0, 0, 0));
      idle(3, 1'b0);

      // Register zero never stalls.
      issue(mk(1, 0,0, 0,0, 0, 1,1, 0, 0));
      issue(mk(1, 0,1, 0,1, 0, 1,0, 6, 0));
      idle(3, 1'b0);

      // Flush during a hazard.
      issue(mk(1, 0,0, 0,0, 0, 1,1, 4, 0));
      step(mk(1, 4,1, 0,0, 0, 1,0, 7, 1), 1'b0, st);
      idle(3, 1'b0);

      // Older load behind a younger ALU producer of the same register.
      issue(mk(1, 0,0, 0,0, 0, 1,1, 2, 0));
      issue(mk(1, 0,0, 0,0, 0, 1,0, 2, 0));
      issue(mk(1, 2,1, 0,0, 1, 0,0, 0, 0));
      idle(3, 1'b0);

      // Reset in the middle of a branch stall.
      issue(mk(1, 0,0, 0,0, 0, 1,1, 8, 0));
      step(mk(1, 8,1, 0,0, 1, 0,0, 0, 0), 1'b0, st);
      step(mk(1, 8,1, 0,0, 1, 0,0, 0, 0), 1'b1, st);
      idle(2, 1'b0);

      // Randomized traffic; a stalled instruction stays in ID.
      cur = rand_instr();
      for (int n = 0; n < 3000; n++) begin
         step(cur, ($urandom_range(0, 99) == 0), st);
         if (st) cur.fl = ($urandom_range(0, 9) == 0);
         else    cur = rand_instr();
      end
      idle(2, 1'b0);

      @(negedge clk);
      #1;
      n_cmp++;
      if (expq.size() != 0) begin
         n_bad++;
         $display("FAIL drain %0d expectations left unchecked (want 0)", expq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
